regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the CPU register file. It accepts writeback requests from NREQ producers (ALU, load unit, multi-cycle mul/div) through valid/ready handshakes and grants one per cycle round-robin. The granted write is registered onto the single regfile write port (we/rd/wd). It also keeps a per-register busy scoreboard, so issue logic can detect RAW and WAW hazards against writes still in flight.

---
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, plus a per-register
// busy scoreboard used by issue logic for RAW/WAW hazard detection.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [32*NREQ-1:0]   req_wd,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic                 issue_stall,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [31:0]          rf_wd,
  output logic [31:0]          busy_vec
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_rd_q, rf_rd_d;
  logic [31:0]   rf_wd_q, rf_wd_d;
  logic [31:0]   busy_q, busy_d;

  logic [4:0]    rd_arr [NREQ];
  logic [31:0]   wd_arr [NREQ];

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   idx;
  logic            found;
  logic            accept;
  logic [4:0]      gnt_rd;
  logic [31:0]     gnt_wd;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rd_arr[g] = req_rd[5*g +: 5];
    assign wd_arr[g] = req_wd[32*g +: 32];
  end

  // Scan from ptr+1 around to ptr itself; first valid requester wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = PW'((32'(ptr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        gnt_idx    = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  assign accept    = found && !reset;
  assign req_ready = reset ? '0 : grant;
  assign gnt_rd    = rd_arr[gnt_idx];
  assign gnt_wd    = wd_arr[gnt_idx];

  always_comb begin
    ptr_d   = ptr_q;
    rf_we_d = 1'b0;
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;
    busy_d  = busy_q;
    if (accept) begin
      ptr_d   = gnt_idx;
      rf_we_d = (gnt_rd != 5'd0);
      rf_rd_d = gnt_rd;
      rf_wd_d = gnt_wd;
      if (gnt_rd != 5'd0) begin
        busy_d[gnt_rd] = 1'b0;
      end
    end
    // Set after clear so a same-edge issue to the retiring register stays busy.
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= PW'(NREQ - 1);
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
      busy_q  <= busy_d;
    end
  end

  assign issue_stall = !reset && busy_q[issue_rd];
  assign rs1_busy    = !reset && busy_q[rs1];
  assign rs2_busy    = !reset && busy_q[rs2];

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wd    = rf_wd_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=3): arbitration, write port and scoreboard.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_wd;
  logic [2:0]  req_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [31:0] busy_vec;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.NREQ(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rd(req_rd), .req_wd(req_wd), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] wd);
    req_valid[i]       = v;
    req_rd[5*i +: 5]   = rd;
    req_wd[32*i +: 32] = wd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    set_req(0, 1'b1, 5'd1, 32'h0000_0A00);
    set_req(1, 1'b1, 5'd2, 32'h0000_0A01);
    set_req(2, 1'b1, 5'd3, 32'h0000_0A02);
    tick(); tick();
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=00000000", busy_vec); end
    checks++; if (rf_rd !== 5'd0 || rf_wd !== 32'h0) begin errors++; $display("FAIL reset_rf got=%0d/%h exp=0/00000000", rf_rd, rf_wd); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_first_grant got=%b exp=001", req_ready); end
    req_valid = 3'b000;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy;
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h1000_0000);
    set_req(1, 1'b1, 5'd2, 32'h1000_0001);
    set_req(2, 1'b1, 5'd3, 32'h1000_0002);
    #1;
    for (int c = 0; c < 6; c++) begin
      exp_rdy = 3'b001 << (c % 3);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, req_ready, exp_rdy); end
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_rd !== 5'((c % 3) + 1) || rf_wd !== (32'h1000_0000 + 32'(c % 3))) begin
        errors++; $display("FAIL rr_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", c, rf_we, rf_rd, rf_wd, (c % 3) + 1, 32'h1000_0000 + 32'(c % 3));
      end
    end
    req_valid = 3'b000;
    tick();
    checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd3 || rf_wd !== 32'h1000_0002) begin
      errors++; $display("FAIL rr_idle_hold got=%b/%0d/%h exp=0/3/10000002", rf_we, rf_rd, rf_wd);
    end
  endtask

  task automatic test_raw();
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0; rs1 = 5'd5; rs2 = 5'd6;
    #1;
    checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin errors++; $display("FAIL raw_busy got=%b%b exp=10", rs1_busy, rs2_busy); end
    checks++; if (busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL raw_vec got=%h exp=00000020", busy_vec); end
    set_req(2, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    checks++; if (req_ready !== 3'b100 || rs1_busy !== 1'b1) begin errors++; $display("FAIL raw_accept got=%b/%b exp=100/1", req_ready, rs1_busy); end
    tick();
    req_valid = 3'b000;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL raw_write got=%b/%0d/%h exp=1/5/deadbeef", rf_we, rf_rd, rf_wd);
    end
    checks++; if (rs1_busy !== 1'b0 || busy_vec !== 32'h0) begin errors++; $display("FAIL raw_clear got=%b/%h exp=0/00000000", rs1_busy, busy_vec); end
  endtask

  task automatic test_waw_x0();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL waw_stall got=%b exp=1", issue_stall); end
    issue_rd = 5'd3;
    #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL waw_nostall got=%b exp=0", issue_stall); end
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs1 = 5'd0;
    tick();
    issue_valid = 1'b0;
    checks++; if (busy_vec !== 32'h0000_0080 || rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_issue got=%h/%b exp=00000080/0", busy_vec, rs1_busy); end
    set_req(0, 1'b1, 5'd0, 32'h0000_1234);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready got=%b exp=001", req_ready); end
    tick();
    req_valid = 3'b000;
    checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== 32'h0000_1234 || busy_vec !== 32'h0000_0080) begin
      errors++; $display("FAIL x0_write got=%b/%0d/%h/%h exp=0/0/00001234/00000080", rf_we, rf_rd, rf_wd, busy_vec);
    end
  endtask

  task automatic test_set_clear();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    set_req(1, 1'b1, 5'd9, 32'h0000_0099);
    #1;
    checks++; if (req_ready !== 3'b010 || busy_vec !== 32'h0000_0280) begin errors++; $display("FAIL sc_pre got=%b/%h exp=010/00000280", req_ready, busy_vec); end
    tick();
    issue_valid = 1'b0;
    checks++; if (busy_vec !== 32'h0000_0280 || rf_we !== 1'b1 || rf_rd !== 5'd9) begin
      errors++; $display("FAIL sc_busy got=%h/%b/%0d exp=00000280/1/9", busy_vec, rf_we, rf_rd);
    end
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL sc_regrant got=%b exp=010", req_ready); end
    tick();
    issue_valid = 1'b0; req_valid = 3'b000;
    checks++; if (busy_vec !== 32'h0000_00A0) begin errors++; $display("FAIL sc_vec got=%h exp=000000a0", busy_vec); end
  endtask

  task automatic test_reset_mid();
    set_req(1, 1'b1, 5'd4, 32'h0000_0044);
    issue_rd = 5'd7; rs1 = 5'd5;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b000 || issue_stall !== 1'b0 || rs1_busy !== 1'b0) begin
      errors++; $display("FAIL mid_gate got=%b/%b/%b exp=000/0/0", req_ready, issue_stall, rs1_busy);
    end
    tick();
    reset = 1'b0;
    checks++; if (busy_vec !== 32'h0 || rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== 32'h0) begin
      errors++; $display("FAIL mid_state got=%h/%b/%0d/%h exp=00000000/0/0/00000000", busy_vec, rf_we, rf_rd, rf_wd);
    end
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL mid_grant got=%b exp=010", req_ready); end
    tick();
    req_valid = 3'b000;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wd !== 32'h0000_0044) begin
      errors++; $display("FAIL mid_write got=%b/%0d/%h exp=1/4/00000044", rf_we, rf_rd, rf_wd);
    end
  endtask

  initial begin
    req_valid = '0; req_rd = '0; req_wd = '0;
    test_reset();
    test_round_robin();
    test_raw();
    test_waw_x0();
    test_set_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
